// File: rtl/local_ni_pkg.sv
// Shared types, widths and the timestamp helper for the local network interface.
// The global.vh macros are given fallback values here so the slice also builds on its own.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 4
`endif
`ifndef TIME_POS
`define TIME_POS 24
`endif
`ifndef MAX_TIME
`define MAX_TIME ((1 << `TIME_WIDTH) - 1)
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 4
`endif
`ifndef NI_TIME_WRAP
`define NI_TIME_WRAP (`MAX_TIME - 1)
`endif

package local_ni_pkg;

  localparam int DATA_W    = `DATA_WIDTH;
  localparam int TIME_W    = `TIME_WIDTH;
  localparam int TIME_LSB  = `TIME_POS;
  localparam int VALID_BIT = `VALID_POS;
  localparam int COUNT_W   = `PC_INDEX_WIDTH;

  typedef logic [DATA_W-1:0] flit_t;
  typedef logic [TIME_W-1:0] ni_time_t;

  // Last value the time counter may hold; MAX_TIME itself means "no flit".
  localparam ni_time_t TIME_WRAP = TIME_W'(`NI_TIME_WRAP);

  // Replace the time field with the local counter and mark the flit valid.
  function automatic flit_t stamp_flit(input flit_t f, input ni_time_t t);
    flit_t r;
    r = f;
    r[TIME_LSB +: TIME_W] = t;
    r[VALID_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/local_ni_fifo.sv
// ni_fifo: synchronous show-ahead FIFO. The head is visible without a pop,
// reads as zero when empty, and a push is accepted while full if a pop
// frees the slot in the same cycle.
module ni_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every stored entry at once.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty/full come from the pointers, and rdata is masked while empty.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/local_ni.sv
// local_ni: network interface on the router's local port. Timestamps and
// queues core flits for injection, and captures every ejected flit into a
// queue for the core, flagging any that cannot be absorbed.
module local_ni
  import local_ni_pkg::*;
#(
  parameter int INJ_DEPTH      = 4,
  parameter int EJ_DEPTH       = 4,
  parameter int ALMOST_FULL_TH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  core_inj_flit,
  input  logic               core_inj_valid,
  output logic               core_inj_ready,
  output logic [DATA_W-1:0]  inj_flit,
  input  logic               inj_grant,
  input  logic               inj_merge,
  input  logic [DATA_W-1:0]  ej_flit,
  output logic [DATA_W-1:0]  core_ej_flit,
  output logic               core_ej_valid,
  input  logic               core_ej_ready,
  output logic               ej_almost_full,
  output logic               ej_overflow,
  output logic [COUNT_W-1:0] inj_count
);

  localparam int INJ_OCC_W = $clog2(INJ_DEPTH) + 1;
  localparam int EJ_OCC_W  = $clog2(EJ_DEPTH) + 1;

  ni_time_t             time_q;
  logic                 inj_full, inj_empty, inj_push, inj_pop;
  logic [INJ_OCC_W-1:0] inj_occ;
  logic                 ej_full, ej_empty, ej_push, ej_push_ok, ej_pop;
  logic [EJ_OCC_W-1:0]  ej_occ, ej_occ_next;
  logic                 ej_af_next;

  assign core_inj_ready = !inj_full;
  assign inj_push       = core_inj_valid && !inj_full;
  // Grant and merge in the same cycle still consume only one flit.
  assign inj_pop        = (inj_grant || inj_merge) && !inj_empty;

  assign core_ej_valid  = !ej_empty;
  assign ej_push        = ej_flit[VALID_BIT];
  assign ej_pop         = core_ej_valid && core_ej_ready;
  assign ej_push_ok     = ej_push && (!ej_full || ej_pop);

  ni_fifo #(.DEPTH(INJ_DEPTH), .WIDTH(DATA_W)) u_inj_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inj_push),
    .wdata (stamp_flit(core_inj_flit, time_q)),
    .pop   (inj_pop),
    .rdata (inj_flit),
    .full  (inj_full),
    .empty (inj_empty),
    .count (inj_occ)
  );

  ni_fifo #(.DEPTH(EJ_DEPTH), .WIDTH(DATA_W)) u_ej_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ej_push),
    .wdata (ej_flit),
    .pop   (ej_pop),
    .rdata (core_ej_flit),
    .full  (ej_full),
    .empty (ej_empty),
    .count (ej_occ)
  );

  // Post-update ejection occupancy and the almost-full level it implies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ej_occ_next = ej_occ;
    ej_af_next  = 1'b0;
    ej_occ_next = ej_occ + EJ_OCC_W'(ej_push_ok) - EJ_OCC_W'(ej_pop);
    ej_af_next  = (EJ_OCC_W'(EJ_DEPTH) - ej_occ_next) <= EJ_OCC_W'(ALMOST_FULL_TH);
  end

  // Free-running timestamp counter that skips the reserved MAX_TIME value.
  always_ff @(posedge clk) begin
    if (reset)                    time_q <= '0;
    else if (time_q == TIME_WRAP) time_q <= '0;
    else                          time_q <= time_q + TIME_W'(1);
  end

  // Injection counter, sticky overflow flag and registered almost-full.
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_count      <= '0;
      ej_overflow    <= 1'b0;
      ej_almost_full <= 1'b0;
    end else begin
      if (inj_pop) inj_count <= inj_count + COUNT_W'(1);
      if (ej_push && !ej_push_ok) ej_overflow <= 1'b1;
      ej_almost_full <= ej_af_next;
    end
  end

  // Occupancy sanity check on both queues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (inj_occ <= INJ_OCC_W'(INJ_DEPTH));
      assert (ej_occ <= EJ_OCC_W'(EJ_DEPTH));
    end
  end

endmodule

// File: doc/local_ni.md
Name: local_ni

Overview:
- Node-side network interface on the router's local port, opposite the router's local eject/inject stage.
- Accepts flits from the core, timestamps them and queues them. Presents the head flit as the router's local injection input, and pops it when the router grants the injection or merges it.
- Captures every flit the router ejects into an ejection queue for the core.
- Bufferless network: ejection cannot be back-pressured, so the block must absorb or flag every ejected flit.

Parameters:
- INJ_DEPTH, 4, injection queue entries (power of 2, >=2)
- EJ_DEPTH, 4, ejection queue entries (power of 2, >=2)
- ALMOST_FULL_TH, 1, ej_almost_full asserts when free ejection entries <= this value

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_inj_flit  in  `DATA_WIDTH  flit from core; TIME field ignored
- core_inj_valid  in  1  core flit valid
- core_inj_ready  out  1  injection queue can accept
- inj_flit  out  `DATA_WIDTH  head flit driven to router local injection input
- inj_grant  in  1  router took inj_flit this cycle (OR of the per-channel inject enables)
- inj_merge  in  1  router merged the local flit this cycle (merge bit 4)
- ej_flit  in  `DATA_WIDTH  flit ejected by router; valid when `VALID_POS set
- core_ej_flit  out  `DATA_WIDTH  ejection queue head
- core_ej_valid  out  1  ejection head valid
- core_ej_ready  in  1  core consumes head
- ej_almost_full  out  1  ejection queue nearly full
- ej_overflow  out  1  sticky: an ejected flit was dropped
- inj_count  out  `PC_INDEX_WIDTH  number of flits this node injected or merged, wrapping

Behaviour:
- Reset: both queues empty; time counter = 0; inj_count = 0; ej_overflow = 0.
- Outputs after reset: inj_flit = 0 (valid bit low); core_inj_ready = 1; core_ej_valid = 0; core_ej_flit = 0; ej_almost_full = 0.
- Reset asserted mid-operation discards all queued flits in the same clock edge.
- Time counter:
  - Width `TIME_WIDTH; increments every cycle.
  - `MAX_TIME is reserved as "no flit", so the counter wraps from `MAX_TIME-1 to 0 and never holds `MAX_TIME.
- Enqueue (injection):
  - On core_inj_valid && core_inj_ready, write the flit with its `TIME_POS field replaced by the current counter and `VALID_POS forced to 1.
  - core_inj_ready = !inj_full. Push while full is not allowed, even when a pop occurs in the same cycle.
- Injection head:
  - inj_flit is show-ahead: head entry when non-empty, else all zeros.
  - A flit enqueued in cycle N appears on inj_flit in cycle N+1.
  - inj_flit must be driven straight from storage, with no combinational path from inj_grant or inj_merge.
- Pop (injection):
  - Pop when (inj_grant || inj_merge) && !inj_empty.
  - If both are asserted, pop exactly once.
  - If either is asserted while the queue is empty, ignore it.
  - inj_count increments by 1 on each pop.
  - The next head becomes visible the following cycle.
- Ejection capture:
  - When ej_flit[`VALID_POS] = 1, push ej_flit unchanged.
  - Push and pop in the same cycle are allowed, including when the queue is full (the pop frees the slot first).
  - If the queue is full with no pop and a valid flit arrives: drop it, set ej_overflow; occupancy is unchanged.
  - ej_overflow clears only on reset.
  - A flit ejected in cycle N appears on core_ej_flit/core_ej_valid in cycle N+1.
- Ejection handshake:
  - Pop when core_ej_valid && core_ej_ready.
  - core_ej_flit is held stable while valid and not ready.
- ej_almost_full = (EJ_DEPTH - occupancy) <= ALMOST_FULL_TH. It is registered from post-update occupancy.
- Pointers are log2(DEPTH) bits plus one wrap bit; full/empty are derived from the wrap bit.

Decomposition:
- `DATA_WIDTH, `TIME_POS, `TIME_WIDTH, `MAX_TIME, `VALID_POS and `PC_INDEX_WIDTH come from global.vh. Add no new globals except `NI_TIME_WRAP, defined as `MAX_TIME-1.
- One sub-module, ni_fifo, instantiated twice:
  - parameterised synchronous show-ahead FIFO with push, pop, full, empty and occupancy;
  - same-cycle push+pop allowed when full;
  - zero output when empty.
- Policy lives in local_ni: timestamping, pop merging, drop/overflow, counters.

Test Plan:
- Reset, then enqueue 3 flits in cycles 1-3 with counter at 1, 2, 3 → inj_flit TIME = 1, 2, 3 in order; valid bit set; core_inj_ready stays 1.
- Fill the injection queue to 4 with inj_grant = 0 → core_inj_ready = 0. Assert inj_grant and inj_merge together for one cycle → exactly one pop, inj_count = 1, ready = 1 the next cycle.
- inj_grant pulsed while the queue is empty → no pop; inj_count unchanged; inj_flit stays 0.
- Force the counter to `MAX_TIME-1 and enqueue one flit in that cycle and one in the next → stamps are `MAX_TIME-1 then 0; `MAX_TIME is never produced.
- Eject 4 valid flits with core_ej_ready = 0 → ej_almost_full asserts after the 3rd push. A 5th flit is dropped and ej_overflow = 1. Then core_ej_ready = 1 → the first 4 flits drain in order.
- With the ejection queue full, eject a valid flit while core_ej_ready = 1 → no drop, occupancy stays 4, ej_overflow stays 0. Then assert reset → queue empty, ej_overflow = 0.
